// File: rtl/bneuron_seq_layer.sv
// bneuron_seq_layer
// Layer of NNEUR binary neurons sharing one input vector. Each neuron fires when
// popcount(XNOR(x, w)) + bias >= 0. The vector is consumed SWIDTH bits per cycle,
// LSB slice first, with all neurons accumulating in parallel. Weights and biases
// are runtime-loadable through the cfg_* port while the layer is idle.
// VWIDTH must be a multiple of SWIDTH, and 2^CWIDTH >= VWIDTH.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a vector; config writes honoured here
// COMPUTE | NSLICE cycles, one slice per cycle into every accumulator
// DONE    | out_valid high, out_act held until out_ready

module bneuron_seq_layer #(
    parameter int VWIDTH = 32,
    parameter int CWIDTH = 6,
    parameter int NNEUR  = 4,
    parameter int SWIDTH = 8,
    localparam int AW     = (NNEUR > 1) ? $clog2(NNEUR) : 1,
    localparam int NSLICE = VWIDTH / SWIDTH,
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [VWIDTH-1:0] cfg_w,
    input  logic [CWIDTH-1:0] cfg_b,
    output logic              cfg_busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VWIDTH-1:0] in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NNEUR-1:0]  out_act
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [VWIDTH-1:0] w_reg [NNEUR];
    logic [CWIDTH-1:0] b_reg [NNEUR];
    logic [CWIDTH:0]   acc   [NNEUR];

    logic [VWIDTH-1:0] x_sh;
    logic [CNT_W-1:0]  slice_cnt;
    logic              last_slice;

    logic [SWIDTH-1:0]        x_slice;
    logic [SWIDTH-1:0]        w_slice   [NNEUR];
    logic [CWIDTH:0]          slice_pop [NNEUR];
    logic [CWIDTH:0]          acc_next  [NNEUR];
    logic signed [CWIDTH+1:0] act_sum   [NNEUR];
    logic [NNEUR-1:0]         act_next;

    // Count of ones in one slice; result is wide enough for a full vector.
    function automatic logic [CWIDTH:0] popcnt(input logic [SWIDTH-1:0] v);
        logic [CWIDTH:0] cnt;
        cnt = '0;
        for (int j = 0; j < SWIDTH; j++) begin
            cnt = cnt + {{CWIDTH{1'b0}}, v[j]};
        end
        return cnt;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = COMPUTE;
            COMPUTE: if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        cfg_busy  = (state != IDLE);
    end

    // Config register file; writes outside IDLE and to absent neurons fall through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NNEUR; i++) begin
                w_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else if (cfg_we && (state == IDLE)) begin
            for (int i = 0; i < NNEUR; i++) begin
                if (cfg_addr == AW'(i)) begin
                    w_reg[i] <= cfg_w;
                    b_reg[i] <= cfg_b;
                end
            end
        end
    end

    // Per-neuron slice popcount, running sum and final threshold decision.
    always_comb begin
        x_slice    = x_sh[SWIDTH-1:0];
        last_slice = (slice_cnt == CNT_W'(NSLICE - 1));
        act_next   = '0;
        for (int i = 0; i < NNEUR; i++) begin
            w_slice[i] = '0;
            for (int k = 0; k < NSLICE; k++) begin
                if (slice_cnt == CNT_W'(k)) begin
                    w_slice[i] = w_reg[i][k*SWIDTH +: SWIDTH];
                end
            end
            slice_pop[i] = popcnt(~(x_slice ^ w_slice[i]));
            acc_next[i]  = acc[i] + slice_pop[i];
            // Two extra bits keep the unsigned count plus signed bias from wrapping.
            act_sum[i]   = $signed({1'b0, acc_next[i]})
                         + $signed({{2{b_reg[i][CWIDTH-1]}}, b_reg[i]});
            act_next[i]  = ~act_sum[i][CWIDTH+1];
        end
    end

    // Input capture, slice stepping, accumulation and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sh      <= '0;
            slice_cnt <= '0;
            out_act   <= '0;
            for (int i = 0; i < NNEUR; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sh      <= in_vec;
                        slice_cnt <= '0;
                        for (int i = 0; i < NNEUR; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    x_sh      <= x_sh >> SWIDTH;
                    slice_cnt <= slice_cnt + CNT_W'(1);
                    for (int i = 0; i < NNEUR; i++) begin
                        acc[i] <= acc_next[i];
                    end
                    if (last_slice) begin
                        out_act <= act_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bneuron_seq_layer.sv
// Directed bench for bneuron_seq_layer (VWIDTH=32, CWIDTH=6, NNEUR=4, SWIDTH=8).
// Expected activations were worked out by hand from Hamming distances.

module tb_bneuron_seq_layer;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_w;
    logic [5:0]  cfg_b;
    logic        cfg_busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_act;

    int n_vec = 0;
    int n_err = 0;

    bneuron_seq_layer #(
        .VWIDTH(32),
        .CWIDTH(6),
        .NNEUR (4),
        .SWIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_w    (cfg_w),
        .cfg_b    (cfg_b),
        .cfg_busy (cfg_busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_act  (out_act)
    );

    always #5 clk = ~clk;

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] w, input logic [5:0] b);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_w    = w;
        cfg_b    = b;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    // Waits (bounded) for out_valid after an accept; lat counts edges since acceptance.
    task automatic wait_result(output logic [3:0] act, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        act = out_act;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input logic [31:0] v, output logic [3:0] act, output int lat);
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 32'hDEADBEEF;
        wait_result(act, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_w = '0; cfg_b = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, in_ready, cfg_busy, out_act} !== 7'b0100000) begin
            n_err++;
            $display("FAIL reset_state: got ov/ir/busy/act=%b%b%b/%b want 010/0000",
                     out_valid, in_ready, cfg_busy, out_act);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [31:0] vecs [6] = '{32'h00000000, 32'h00000001, 32'h55555555,
                                  32'h9C638421, 32'h0F0F71C7, 32'hF03F7C1F};
        logic [3:0]  exps [6] = '{4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1110, 4'b1100};
        logic [3:0]  act;
        int          lat;
        cfg_write(2'd0, 32'h00000000, -6'sd16);
        cfg_write(2'd1, 32'h00000001, -6'sd15);
        cfg_write(2'd2, 32'h55555555, -6'sd6);
        cfg_write(2'd3, 32'hFFFFFFFE, -6'sd11);
        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v], act, lat);
            n_vec++;
            if (lat !== NS) begin
                n_err++;
                $display("FAIL vec%0d_latency: got %0d want %0d", v, lat, NS);
            end
            n_vec++;
            if (act !== exps[v]) begin
                n_err++;
                $display("FAIL vec%0d_act x=%h: got %b want %b", v, vecs[v], act, exps[v]);
            end
        end
    endtask

    // Leaves the DUT in DONE holding 1110 for the backpressure test.
    task automatic test_latency();
        in_valid = 1'b1;
        in_vec   = 32'h0F0F71C7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 32'h00000000;
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_t1: got ir=%b ov=%b want 0 0", in_ready, out_valid);
        end
        for (int k = 1; k <= NS; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== (k == NS) || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL lat_edge_T+%0d: got ov=%b ir=%b want ov=%b ir=0",
                         k, out_valid, in_ready, (k == NS));
            end
        end
        n_vec++;
        if (out_act !== 4'b1110) begin
            n_err++;
            $display("FAIL lat_act: got %b want 1110", out_act);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] act;
        int         lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 32'h00000001;
        repeat (10) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_act !== 4'b1110 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: got ov=%b act=%b ir=%b want 1 1110 0",
                         out_valid, out_act, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_act !== 4'b1110) begin
            n_err++;
            $display("FAIL bp_release: got ov=%b ir=%b act=%b want 0 1 1110",
                     out_valid, in_ready, out_act);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got busy=%b ir=%b want 1 0", cfg_busy, in_ready);
        end
        wait_result(act, lat);
        n_vec++;
        if (lat !== NS || act !== 4'b0111) begin
            n_err++;
            $display("FAIL bp_next_vec: got lat=%0d act=%b want %0d 0111", lat, act, NS);
        end
    endtask

    task automatic test_cfg_busy();
        logic [3:0] act;
        int         lat;
        in_valid = 1'b1;
        in_vec   = 32'h00000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_w    = 32'hFFFFFFFF;
        cfg_b    = -6'sd16;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        wait_result(act, lat);
        n_vec++;
        if (act !== 4'b0111) begin
            n_err++;
            $display("FAIL cfg_busy_dropped: got %b want 0111", act);
        end
        cfg_write(2'd0, 32'hFFFFFFFF, -6'sd16);
        run_vec(32'h00000000, act, lat);
        n_vec++;
        if (act !== 4'b0110) begin
            n_err++;
            $display("FAIL cfg_idle_write: got %b want 0110", act);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] act;
        int         lat;
        cfg_we   = 1'b1;
        cfg_addr = 2'd3;
        cfg_w    = 32'hFFFFFFFE;
        cfg_b    = 6'sd31;
        in_valid = 1'b1;
        in_vec   = 32'h00000000;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        wait_result(act, lat);
        n_vec++;
        if (act !== 4'b1110 || lat !== NS) begin
            n_err++;
            $display("FAIL cfg_with_accept: got act=%b lat=%0d want 1110 %0d", act, lat, NS);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] act;
        int         lat;
        in_valid = 1'b1;
        in_vec   = 32'h55555555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++;
        if ({out_valid, in_ready, cfg_busy, out_act} !== 7'b0100000) begin
            n_err++;
            $display("FAIL midreset_state: got ov/ir/busy/act=%b%b%b/%b want 010/0000",
                     out_valid, in_ready, cfg_busy, out_act);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_no_output cycle %0d: got ov=%b want 0", k, out_valid);
            end
        end
        run_vec(32'hFFFFFFFF, act, lat);
        n_vec++;
        if (act !== 4'b1111) begin
            n_err++;
            $display("FAIL midreset_cfg_cleared_ones: got %b want 1111", act);
        end
        run_vec(32'h00000000, act, lat);
        n_vec++;
        if (act !== 4'b1111) begin
            n_err++;
            $display("FAIL midreset_cfg_cleared_zeros: got %b want 1111", act);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_latency();
        test_backpressure();
        test_cfg_busy();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
